// File: rtl/gf8_pow_seq.sv
// GF(2^8) exponentiation sequencer: out = base^exp by left-to-right square-and-multiply,
// time-sharing one combinational multiplier reduced by x^8+x^4+x^3+x+1 (0x11B).
module gf8_pow_seq #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_base,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          busy
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The requester holds in_valid and in_base/in_exp until in_ready; the result stays
    // on out_data with out_valid high until the edge where out_ready is seen.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [7:0]    acc_q;
    logic [7:0]    base_q;
    logic [EW-1:0] exp_q;
    logic [IW-1:0] idx_q;

    logic [7:0]    mul_b;
    logic [7:0]    prod_d;

    // Carry-less 8x8 product followed by reduction from the top bit down.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({7'b0, a} << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h011B << (k - 8));
        end
        return p[7:0];
    endfunction

    assign mul_b  = (state_q == MUL) ? base_q : acc_q;
    assign prod_d = gf_mul(acc_q, mul_b);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        base_q  <= in_base;
                        exp_q   <= in_exp;
                        acc_q   <= 8'h01;
                        idx_q   <= IW'(EW - 1);
                        state_q <= SQR;
                    end
                end
                SQR: begin
                    acc_q <= prod_d;
                    // idx is only consumed by MUL when the bit is set, so it is held here
                    if (exp_q[idx_q]) begin
                        state_q <= MUL;
                    end else if (idx_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                MUL: begin
                    acc_q <= prod_d;
                    if (idx_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
